// File: rtl/solitaire_input_ctrl.sv
// solitaire_input_ctrl: push-button front end for the peg-solitaire board core.
// Each raw button is synchronised, debounced and turned into a one-cycle press.
// A small FSM (NAV -> AIM -> ISSUE -> CHECK) moves a cursor and issues a move.
// The selection is presented to the core for exactly one cycle. For the rest of
// the time it is parked off-board at (7,7), because the core has no valid strobe.
// Optional feature macro: SOLITAIRE_CURSOR_WRAP_EN (NAV cursor wraps modulo 7).
module solitaire_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       game_over,
  input  logic [5:0] piece_count,
  output logic [2:0] piece_x,
  output logic [2:0] piece_y,
  output logic [1:0] direction,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       aiming,
  output logic       move_ok,
  output logic       move_bad
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button indices; a lower index has a higher priority, and sel beats all of them.
  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_SEL   = 4;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [2:0] PARK = 3'd7;
  localparam logic [2:0] HOME = 3'd3;

  typedef enum logic [1:0] {S_NAV, S_AIM, S_ISSUE, S_CHECK} state_t;

  logic [4:0]       raw;
  logic [4:0]       sync1, sync2, deb, deb_d, press;
  logic [CNT_W-1:0] cnt [5];

  state_t     state_q, state_d;
  logic [2:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0] dir_q, dir_d;
  logic [5:0] snap_q, snap_d;
  logic       ok_q, ok_d, bad_q, bad_d;

  assign raw = {btn_sel, btn_down, btn_up, btn_right, btn_left};

  // Cursor steps used in NAV. The wrap build cycles through 0..6; otherwise the cursor clamps.
  function automatic logic [2:0] step_dec(input logic [2:0] v);
`ifdef SOLITAIRE_CURSOR_WRAP_EN
    return (v == 3'd0) ? 3'd6 : v - 3'd1;
`else
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
`endif
  endfunction

  function automatic logic [2:0] step_inc(input logic [2:0] v);
`ifdef SOLITAIRE_CURSOR_WRAP_EN
    return (v >= 3'd6) ? 3'd0 : v + 3'd1;
`else
    return (v >= 3'd6) ? 3'd6 : v + 3'd1;
`endif
  endfunction

  // Synchronise, debounce and edge-detect every button.
  // NOTE: state registers use non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Control FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NAV;
      cx_q    <= HOME;
      cy_q    <= HOME;
      dir_q   <= DIR_LEFT;
      snap_q  <= '0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_q   <= dir_d;
      snap_q  <= snap_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic: one action per cycle, in the order sel > LEFT > RIGHT > UP > DOWN.
  always_comb begin
    // NOTE: defaults come first so that no path leaves a signal unassigned (no latches).
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_d   = dir_q;
    snap_d  = snap_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      S_NAV: begin
        if (press[B_SEL]) begin
          if (!game_over) state_d = S_AIM;
        end else if (press[B_LEFT]) begin
          cx_d = step_dec(cx_q);
        end else if (press[B_RIGHT]) begin
          cx_d = step_inc(cx_q);
        end else if (press[B_UP]) begin
          cy_d = step_dec(cy_q);
        end else if (press[B_DOWN]) begin
          cy_d = step_inc(cy_q);
        end
      end
      S_AIM: begin
        if (game_over || press[B_SEL]) begin
          state_d = S_NAV;
        end else if (|press[B_DOWN:B_LEFT]) begin
          if (press[B_LEFT])       dir_d = DIR_LEFT;
          else if (press[B_RIGHT]) dir_d = DIR_RIGHT;
          else if (press[B_UP])    dir_d = DIR_UP;
          else                     dir_d = DIR_DOWN;
          snap_d  = piece_count;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        // The core has already acted on the issued move. A lower count means it jumped a peg.
        if (piece_count < snap_q) begin
          ok_d = 1'b1;
          unique case (dir_q)
            DIR_LEFT:  cx_d = cx_q - 3'd2;
            DIR_RIGHT: cx_d = cx_q + 3'd2;
            DIR_UP:    cy_d = cy_q - 3'd2;
            default:   cy_d = cy_q + 3'd2;
          endcase
        end else begin
          bad_d = 1'b1;
        end
        state_d = S_NAV;
      end
      default: state_d = S_NAV;
    endcase
  end

  assign piece_x   = (state_q == S_ISSUE) ? cx_q : PARK;
  assign piece_y   = (state_q == S_ISSUE) ? cy_q : PARK;
  assign direction = dir_q;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  assign aiming    = (state_q == S_AIM);
  assign move_ok   = ok_q;
  assign move_bad  = bad_q;

endmodule

// File: tb/tb_solitaire_input_ctrl.sv
// tb_solitaire_input_ctrl: scoreboard bench for solitaire_input_ctrl with DEBOUNCE_CYCLES=4.
// A tiny core model removes a peg when a move is issued while 'accept' is set.
// Expected issue and result records are queued as stimulus is driven. A monitor pops and
// compares them whenever the DUT presents a move or a move_ok/move_bad pulse.
module tb_solitaire_input_ctrl;

  localparam int D = 4;
  localparam int HOLD = D + 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;  // {sel, down, up, right, left}
  logic       game_over = 1'b0;
  logic [5:0] piece_count = 6'd32;
  logic       accept = 1'b0;
  logic [2:0] piece_x, piece_y, cursor_x, cursor_y;
  logic [1:0] direction;
  logic       aiming, move_ok, move_bad;

  int checks = 0;
  int errors = 0;
  logic [31:0] issue_q[$];
  logic [31:0] result_q[$];
  int ex = 3;
  int ey = 3;

  solitaire_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn[0]), .btn_right(btn[1]), .btn_up(btn[2]), .btn_down(btn[3]), .btn_sel(btn[4]),
    .game_over(game_over), .piece_count(piece_count),
    .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .aiming(aiming), .move_ok(move_ok), .move_bad(move_bad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Core model: a move issued while 'accept' is set removes one peg on that edge.
  always @(posedge clk)
    if (accept && piece_x != 3'd7) piece_count <= piece_count - 6'd1;

  // Monitor: compare every issued move and every result pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (piece_x != 3'd7 || piece_y != 3'd7) begin
        if (issue_q.size() == 0) check("issue_unexpected", {piece_x, piece_y, direction}, 32'hFFFF);
        else check("issue", {24'd0, piece_x, piece_y, direction}, issue_q.pop_front());
      end
      if (move_ok || move_bad) begin
        if (result_q.size() == 0) check("result_unexpected", {move_ok, move_bad}, 32'hFFFF);
        else check("result", {24'd0, move_ok, move_bad, cursor_x, cursor_y}, result_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ex = 3;
    ey = 3;
  endtask

  task automatic press(input logic [4:0] mask);
    @(negedge clk);
    btn = mask;
    repeat (HOLD) @(negedge clk);
    btn = '0;
    repeat (HOLD) @(negedge clk);
  endtask

  function automatic int nav_dec(input int v);
`ifdef SOLITAIRE_CURSOR_WRAP_EN
    return (v == 0) ? 6 : v - 1;
`else
    return (v == 0) ? 0 : v - 1;
`endif
  endfunction

  function automatic int nav_inc(input int v);
`ifdef SOLITAIRE_CURSOR_WRAP_EN
    return (v == 6) ? 0 : v + 1;
`else
    return (v == 6) ? 6 : v + 1;
`endif
  endfunction

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, cursor_x, ex);
    check({tag, "_y"}, cursor_y, ey);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_piece_x", piece_x, 3'd7);
    check("rst_piece_y", piece_y, 3'd7);
    check("rst_direction", direction, 2'b00);
    check_cursor("rst_cursor");
    check("rst_aiming", aiming, 1'b0);
    check("rst_ok_bad", {move_ok, move_bad}, 2'b00);

    // Debounce latency: raw goes high before edge 1; the cursor moves on edge 8.
    @(negedge clk);
    btn = 5'b00010;
    repeat (7) @(negedge clk);
    check("deb_before_x", cursor_x, 3'd3);
    @(negedge clk);
    check("deb_after_x", cursor_x, 3'd4);
    repeat (HOLD) @(negedge clk);
    check("deb_single_x", cursor_x, 3'd4);
    btn = '0;
    repeat (HOLD) @(negedge clk);
    // A 3-cycle glitch must be filtered out.
    btn = 5'b00010;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (HOLD) @(negedge clk);
    check("glitch_x", cursor_x, 3'd4);

    // Legal move: (3,5) jumping UP lands on (3,3).
    do_reset();
    press(5'b01000);
    press(5'b01000);
    ey = 5;
    check_cursor("nav_35");
    press(5'b10000);
    check("aim_on", aiming, 1'b1);
    accept = 1'b1;
    issue_q.push_back({24'd0, 3'd3, 3'd5, 2'b10});
    result_q.push_back({24'd0, 2'b10, 3'd3, 3'd3});
    press(5'b00100);
    accept = 1'b0;
    ey = 3;
    check_cursor("legal_land");
    check("legal_aim_off", aiming, 1'b0);
    check("legal_dir_held", direction, 2'b10);

    // Illegal move: LEFT from (3,3) with no peg removed.
    do_reset();
    press(5'b10000);
    issue_q.push_back({24'd0, 3'd3, 3'd3, 2'b00});
    result_q.push_back({24'd0, 2'b01, 3'd3, 3'd3});
    press(5'b00001);
    check_cursor("illegal_stay");

    // Cancel: sel, then sel again; no move may be issued.
    press(5'b10000);
    check("cancel_aim_on", aiming, 1'b1);
    press(5'b10000);
    check("cancel_aim_off", aiming, 1'b0);
    // Priority: sel and LEFT debounced together -> AIM, cursor unchanged.
    press(5'b10001);
    check("prio_aim", aiming, 1'b1);
    check_cursor("prio_cursor");
    press(5'b10000);

    // Edges: 5 LEFT presses, then 7 RIGHT presses.
    for (int k = 0; k < 5; k++) begin
      press(5'b00001);
      ex = nav_dec(ex);
    end
    check_cursor("left_edge");
    for (int k = 0; k < 7; k++) begin
      press(5'b00010);
      ex = nav_inc(ex);
    end
    check_cursor("right_edge");

    // game_over in AIM forces NAV on the next edge; sel is ignored while game_over is high.
    press(5'b10000);
    check("go_aim_on", aiming, 1'b1);
    game_over = 1'b1;
    @(negedge clk);
    check("go_forced_nav", aiming, 1'b0);
    press(5'b10000);
    check("go_sel_ignored", aiming, 1'b0);
    game_over = 1'b0;

    // Asynchronous reset during ISSUE clears everything at once, with no partial move afterwards.
    press(5'b10000);
    issue_q.push_back({24'd0, ex[2:0], ey[2:0], 2'b10});
    @(negedge clk);
    btn = 5'b00100;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (piece_x != 3'd7) seen = 1'b1;
    end
    check("issue_seen", seen, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    ex = 3;
    ey = 3;
    check("arst_piece_x", piece_x, 3'd7);
    check("arst_piece_y", piece_y, 3'd7);
    check_cursor("arst_cursor");
    check("arst_direction", direction, 2'b00);
    btn = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * HOLD) @(negedge clk);
    check("post_arst_ok_bad", {move_ok, move_bad}, 2'b00);

    check("issue_q_empty", issue_q.size(), 0);
    check("result_q_empty", result_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
